sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO for the datapath buffering layer. It is the next generation of the team's 8x8 FIFO.
- Generalised WIDTH and DEPTH.
- Correct simultaneous push/pop accounting.
- Programmable almost-full/almost-empty thresholds, an occupancy output and sticky overflow/underflow error flags.
- Sits between producer and consumer stages in one clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr  in  1  push request.
- data_in  in  WIDTH  push data.
- rd  in  1  pop request.
- data_out  out  WIDTH  popped word.
- rd_valid  out  1  data_out holds a newly popped word this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1  occupancy, where AW = $clog2(DEPTH).
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset: one clock and a synchronous, active-high reset (clk, rst).
  - When rst=1 at a rising edge, the following clear to 0: wr_ptr, rd_ptr, count, data_out, rd_valid, overflow, underflow.
  - Memory contents are not cleared.
  - rst has priority over wr/rd in the same cycle. Reset mid-stream discards all stored words.
- Push accept: push = wr & !full. Writes data_in to mem[wr_ptr]; wr_ptr advances by 1, modulo DEPTH (natural AW-bit wrap).
- Pop accept: pop = rd & !empty. Reads mem[rd_ptr]; rd_ptr advances by 1, modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push & pop together: unchanged, both pointers advance.
  - neither: hold.
- When full with wr=rd=1: pop accepted, push rejected, count decrements, overflow sets.
- When empty with wr=rd=1: push accepted, pop rejected, count increments, underflow sets.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the count register, with no extra latency.
- Read latency (default): 1 cycle. data_out is registered at the edge where pop is accepted. rd_valid=1 for exactly the cycle after an accepted pop; otherwise rd_valid=0 and data_out holds its last value.
- Errors: overflow sets on wr & full; underflow sets on rd & empty. Both remain set until rst.
- Write and read of the same entry in one cycle is possible only when count==DEPTH or 0. This cannot happen, because push is gated when full and pop is gated when empty. No bypass path is needed.
- Elaboration check: AF_LEVEL <= DEPTH, AE_LEVEL < DEPTH, and DEPTH is a power of two. A violation is an elaboration error.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally, rd_valid = !empty.
  - rd acts as an acknowledge that consumes the head word; latency 0.
  - data_out is undefined while empty.
- Undefined: the registered 1-cycle read behaviour above.
- Flags, count and error rules are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - default constants FIFO_WIDTH_DEF=8 and FIFO_DEPTH_DEF=8;
  - a count-width helper function, clog2(DEPTH)+1.
- Sub-module fifo_mem: a simple dual-port register array (one synchronous write port, one asynchronous read address port). The top level owns pointers, count, flags and the output register.

Test Plan (WIDTH=8, DEPTH=8, AF=6, AE=2):
- Fill: reset, push 0x10..0x17 over 8 cycles.
  - count goes 1..8.
  - almost_full rises when count reaches 6.
  - full=1 after the 8th push.
  - A 9th push of 0xFF sets overflow and leaves count=8.
- Drain: from full, pop 8 times.
  - data_out = 0x10..0x17 in order, each one cycle after its pop, with rd_valid pulses.
  - empty=1 at the end.
  - A further pop sets underflow, and rd_valid stays 0.
- Simultaneous: with count=3, hold wr=rd=1 for 20 cycles using an incrementing pattern.
  - count stays 3.
  - Output order matches input order across pointer wrap-around (20 > DEPTH).
- Boundaries: when full, wr=rd=1 gives count 7 and overflow=1. When empty, wr=rd=1 gives count 1, underflow=1 and rd_valid=0.
- Reset mid-operation: with count=5 and overflow=1, assert rst for 1 cycle with wr=1.
  - Next cycle: count=0, empty=1, overflow=0, data_out=0x00, rd_valid=0.
  - A subsequent push/pop of 0xA5 returns 0xA5.
- FWFT build (SYNC_FIFO_FWFT_EN): push 0x3C.
  - data_out=0x3C and rd_valid=1 in the cycle after the push edge, with no rd.
  - After rd=1 for one cycle: empty=1, rd_valid=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 8;

    // Occupancy needs one bit more than the address so that "full" (== DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the write word on the rising edge when write-enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy, programmable almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Build option: SYNC_FIFO_FWFT_EN selects first-word fall-through output
// (head word visible combinationally, rd acknowledges it). Without it the
// output is registered with one cycle of read latency.
//
// Handshake: a push is accepted when wr=1 and full=0; a pop is accepted when
// rd=1 and empty=0. Requests made while full/empty are dropped and latch the
// matching sticky error flag. rd_valid marks data_out as a fresh word.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    // Reject illegal configurations at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be >= 1");
    end
    if (AF_LEVEL > DEPTH || AF_LEVEL < 0) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must be within 0..DEPTH");
    end
    if (AE_LEVEL >= DEPTH || AE_LEVEL < 0) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must be within 0..DEPTH-1");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rd_data;

    // Gate requests with the current flags; since push is blocked when full and
    // pop when empty, a same-entry read/write in one cycle cannot occur.
    assign push = wr & ~full;
    assign pop  = rd & ~empty;

    // Flags decode straight from the count register.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Advance pointers on accepted transfers; the AW-bit width gives the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Track occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Latch error conditions until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr & full)  overflow_q  <= 1'b1;
            if (rd & empty) underflow_q <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; it is only meaningful while not empty.
    assign data_out = rd_data;
    assign rd_valid = ~empty;
`else
    logic [WIDTH-1:0] data_out_q;
    logic             rd_valid_q;

    // Capture the head word on an accepted pop; otherwise hold the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (pop) data_out_q <= rd_data;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF=6, AE=2).
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based reference model. Build with SYNC_FIFO_FWFT_EN for the FWFT variant.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr;
    logic [WIDTH-1:0] data_in;
    logic             rd;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf;
    logic             m_unf;
    logic             m_rv;
    logic [WIDTH-1:0] m_dout;

    int n_checks = 0;
    int n_pass   = 0;

    // Clock and reset block
    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model of one rising edge, derived from the FIFO rules on occupancy.
    task automatic model_edge(input bit r, input bit w, input logic [WIDTH-1:0] d, input bit rr);
        bit was_full;
        bit was_empty;
        if (r) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_rv   = 1'b0;
            m_dout = '0;
        end else begin
            was_full  = (exp_q.size() == DEPTH);
            was_empty = (exp_q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (rr && was_empty) m_unf = 1'b1;
            m_rv = rr && !was_empty;
            if (m_rv) m_dout = exp_q.pop_front();
            if (w && !was_full) exp_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        int n;
        n = exp_q.size();
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == DEPTH));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        check("rd_valid", 32'(rd_valid), 32'(n != 0));
        if (n != 0) check("data_out", 32'(data_out), 32'(exp_q[0]));
`else
        check("rd_valid", 32'(rd_valid), 32'(m_rv));
        check("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    // Driver: apply inputs for one cycle, advance the model, sample after the edge.
    task automatic step(input bit r, input bit w, input logic [WIDTH-1:0] d, input bit rr);
        rst     = r;
        wr      = w;
        data_in = d;
        rd      = rr;
        @(posedge clk);
        model_edge(r, w, d, rr);
        #1;
        compare_all();
    endtask

    initial begin
        int pwr;
        int prd;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0;

        // Fill
        step(1, 0, 8'h00, 0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'(8'h10 + i), 0);
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'(i + 1 >= 6));
        end
        check("fill_full", 32'(full), 32'd1);
        step(0, 1, 8'hFF, 0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);

        // Drain
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 8'h00, 1);
`ifndef SYNC_FIFO_FWFT_EN
            check("drain_data", 32'(data_out), 32'(8'h10 + i));
            check("drain_rv", 32'(rd_valid), 32'd1);
`endif
        end
        check("drain_empty", 32'(empty), 32'd1);
        step(0, 0, 8'h00, 1);
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_rv", 32'(rd_valid), 32'd0);

        // Simultaneous push/pop across pointer wrap
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h20 + i), 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 8'(8'h30 + i), 1);
            check("simul_count", 32'(count), 32'd3);
        end

        // Boundary: full with wr=rd=1
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h50 + i), 0);
        step(0, 1, 8'h99, 1);
        check("bnd_full_count", 32'(count), 32'd7);
        check("bnd_full_ovf", 32'(overflow), 32'd1);

        // Boundary: empty with wr=rd=1
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1);
        step(0, 1, 8'h66, 1);
        check("bnd_empty_count", 32'(count), 32'd1);
        check("bnd_empty_unf", 32'(underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check("bnd_empty_rv", 32'(rd_valid), 32'd0);
`endif

        // Reset mid-operation with count=5 and overflow set
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h70 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        step(1, 1, 8'h77, 0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rv", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_dout", 32'(data_out), 32'd0);
`endif
        step(0, 1, 8'hA5, 0);
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_a5", 32'(data_out), 32'hA5);
        step(0, 0, 8'h00, 1);
`else
        step(0, 0, 8'h00, 1);
        check("post_rst_a5", 32'(data_out), 32'hA5);
`endif

`ifdef SYNC_FIFO_FWFT_EN
        // Fall-through visibility without rd
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h3C, 0);
        check("fwft_dout", 32'(data_out), 32'h3C);
        check("fwft_rv", 32'(rd_valid), 32'd1);
        step(0, 0, 8'h00, 1);
        check("fwft_empty", 32'(empty), 32'd1);
        check("fwft_rv_off", 32'(rd_valid), 32'd0);
`endif

        // Randomized traffic with shifting push/pop bias and rare resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pwr = $urandom_range(20, 80);
                prd = $urandom_range(20, 80);
            end
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < pwr,
                 8'($urandom),
                 $urandom_range(0, 99) < prd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
